cdb_arbiter: RTL and testbench

//  Common-data-bus arbiter for the Tomasulo core. Add, mul and branch units present finished results
//  (ROB tag + value). The arbiter grants one per cycle, oldest-in-program-order first, and drives a

---
 rtl/cdb_arbiter.sv | 84 ++++++++
 tb/tb_cdb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants the oldest finished FU result (age relative to ROB head), registers it onto the CDB.
// Latency: result granted at edge N is on the bus from edge N until the edge it is consumed (or flushed).
// Backpressure: grants only while the output slot is free (empty or being consumed); flush blocks every grant.
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic                      clk1,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [TAG_W-1:0]          rob_head,
  input  logic                      flush,
  input  logic                      cdb_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [N_REQ-1:0]          cdb_src
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic              slot_free;
  logic              grant;
  logic              any_vld;
  logic [TAG_W-1:0]  age;
  logic [TAG_W-1:0]  best_age;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  logic [N_REQ-1:0]  win_onehot;

  // Age is the modular distance from the ROB head; strict '<' keeps the lowest index on a tie.
  always_comb begin
    any_vld    = 1'b0;
    age        = '0;
    best_age   = '0;
    win_tag    = '0;
    win_data   = '0;
    win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      age = req_tag[i*TAG_W +: TAG_W] - rob_head;
      if (req_valid[i] && (!any_vld || (age < best_age))) begin
        any_vld       = 1'b1;
        best_age      = age;
        win_tag       = req_tag[i*TAG_W +: TAG_W];
        win_data      = req_data[i*DATA_W +: DATA_W];
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign slot_free = (state == EMPTY) || cdb_ready;
  assign grant     = rst_n && !flush && slot_free && any_vld;
  assign req_ready = grant ? win_onehot : '0;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      // Squash drops the pending broadcast but leaves the last tag/data visible.
      state     <= EMPTY;
      cdb_valid <= 1'b0;
    end else if (grant) begin
      state     <= FULL;
      cdb_valid <= 1'b1;
      cdb_tag   <= win_tag;
      cdb_data  <= win_data;
      cdb_src   <= win_onehot;
    end else if ((state == FULL) && cdb_ready) begin
      state     <= EMPTY;
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic against an age-ordered reference model.
module tb_cdb_arbiter;
  localparam int N_REQ  = 3;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2**TAG_W;

  logic                    clk1 = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [TAG_W-1:0]        rob_head;
  logic                    flush;
  logic                    cdb_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [N_REQ-1:0]        cdb_src;

  cdb_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk1(clk1), .rst_n(rst_n), .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .rob_head(rob_head), .flush(flush), .cdb_ready(cdb_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  always #5 clk1 = ~clk1;

  int errors = 0;
  int checks = 0;

  // Reference model: one broadcast slot plus a queue of granted tags awaiting delivery.
  bit                m_valid = 1'b0;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_data;
  logic [N_REQ-1:0]  m_src;
  logic [TAG_W-1:0]  exp_q[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int oldest();
    int best = -1;
    int best_age = DEPTH;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) begin
        int age = (int'(req_tag[i*TAG_W +: TAG_W]) - int'(rob_head) + DEPTH) % DEPTH;
        if (age < best_age) begin
          best = i;
          best_age = age;
        end
      end
    end
    return best;
  endfunction

  task automatic set_req(input int u, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    req_valid[u] = 1'b1;
    req_tag[u*TAG_W +: TAG_W] = t;
    req_data[u*DATA_W +: DATA_W] = d;
  endtask

  // One clock: check DUT against model at negedge, advance model, step past the edge.
  task automatic cycle();
    int w;
    logic [N_REQ-1:0] exp_rdy;
    logic [TAG_W-1:0] front;
    @(negedge clk1);
    w = oldest();
    exp_rdy = '0;
    if (rst_n && !flush && (!m_valid || cdb_ready) && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("onehot", 32'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0)), 32'd1);
    chk("cdb_valid", 32'(cdb_valid), 32'(m_valid));
    if (m_valid) begin
      chk("cdb_tag", 32'(cdb_tag), 32'(m_tag));
      chk("cdb_data", 32'(cdb_data), 32'(m_data));
      chk("cdb_src", 32'(cdb_src), 32'(m_src));
    end
    if (!rst_n) begin
      exp_q.delete();
      m_valid = 1'b0;
    end else begin
      if (cdb_valid && cdb_ready && !flush) begin
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          front = exp_q.pop_front();
          chk("sb_order", 32'(cdb_tag), 32'(front));
        end
      end else if (flush && m_valid && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      if (flush) m_valid = 1'b0;
      else if (exp_rdy != '0) begin
        m_valid = 1'b1;
        m_tag   = req_tag[w*TAG_W +: TAG_W];
        m_data  = req_data[w*DATA_W +: DATA_W];
        m_src   = exp_rdy;
        exp_q.push_back(m_tag);
      end else if (cdb_ready) m_valid = 1'b0;
    end
    @(posedge clk1);
    #1;
    req_valid = req_valid & ~exp_rdy;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; cdb_ready = 1'b1; rob_head = '0;
    req_valid = '0; req_tag = '0; req_data = '0;

    // Reset with every unit requesting
    set_req(0, 3'd0, 16'h00a0); set_req(1, 3'd1, 16'h00a1); set_req(2, 3'd2, 16'h00a2);
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(cdb_valid), 32'd0);
    cycle();
    chk("rst_tag", 32'(cdb_tag), 32'd0);
    chk("rst_data", 32'(cdb_data), 32'd0);
    chk("rst_src", 32'(cdb_src), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_tag", 32'(cdb_tag), 32'd0);
    chk("post_rst_valid", 32'(cdb_valid), 32'd1);
    repeat (3) cycle();
    chk("drain_valid", 32'(cdb_valid), 32'd0);

    // Single request
    set_req(0, 3'd2, 16'h1234);
    cycle();
    chk("single_valid", 32'(cdb_valid), 32'd1);
    chk("single_tag", 32'(cdb_tag), 32'd2);
    chk("single_data", 32'(cdb_data), 32'h1234);
    chk("single_src", 32'(cdb_src), 32'b001);
    cycle();

    // Age order across the tag wrap
    rob_head = 3'd6;
    set_req(0, 3'd1, 16'h1111); set_req(1, 3'd7, 16'h7777); set_req(2, 3'd0, 16'h0000);
    cycle();
    chk("wrap1_tag", 32'(cdb_tag), 32'd7);
    chk("wrap1_src", 32'(cdb_src), 32'b010);
    cycle();
    chk("wrap2_tag", 32'(cdb_tag), 32'd0);
    chk("wrap2_src", 32'(cdb_src), 32'b100);
    cycle();
    chk("wrap3_tag", 32'(cdb_tag), 32'd1);
    chk("wrap3_valid", 32'(cdb_valid), 32'd1);
    cycle();
    chk("wrap_empty", 32'(cdb_valid), 32'd0);

    // Backpressure holds the bus and blocks grants
    rob_head = 3'd0;
    set_req(0, 3'd3, 16'h3333);
    cycle();
    cdb_ready = 1'b0;
    set_req(1, 3'd4, 16'h4444);
    repeat (4) begin
      cycle();
      chk("bp_hold_tag", 32'(cdb_tag), 32'd3);
      chk("bp_mul_waiting", 32'(req_valid[1]), 32'd1);
    end
    cdb_ready = 1'b1;
    cycle();
    chk("bp_mul_tag", 32'(cdb_tag), 32'd4);
    chk("bp_mul_src", 32'(cdb_src), 32'b010);
    cycle();

    // Flush drops the pending broadcast and outranks a grant
    set_req(0, 3'd5, 16'h5555);
    cycle();
    cdb_ready = 1'b0;
    set_req(0, 3'd6, 16'h6666);
    flush = 1'b1;
    cycle();
    chk("flush_valid", 32'(cdb_valid), 32'd0);
    chk("flush_tag_kept", 32'(cdb_tag), 32'd5);
    flush = 1'b0;
    cycle();
    chk("after_flush_tag", 32'(cdb_tag), 32'd6);
    chk("after_flush_valid", 32'(cdb_valid), 32'd1);
    cdb_ready = 1'b1;
    cycle();

    // Random traffic with unique in-flight tags
    for (int n = 0; n < 10000; n++) begin
      for (int u = 0; u < N_REQ; u++) begin
        if (!req_valid[u] && $urandom_range(0, 1) == 1) begin
          int t;
          bit used;
          do begin
            t = $urandom_range(0, DEPTH - 1);
            used = 1'b0;
            for (int k = 0; k < N_REQ; k++)
              if (k != u && req_valid[k] && int'(req_tag[k*TAG_W +: TAG_W]) == t) used = 1'b1;
          end while (used);
          set_req(u, TAG_W'(t), DATA_W'($urandom));
        end
      end
      if ($urandom_range(0, 3) == 0) rob_head = TAG_W'($urandom);
      cdb_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end

    flush = 1'b0; cdb_ready = 1'b1; req_valid = '0;
    repeat (2) cycle();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
